cacheline_burst_adaptor: RTL

- Responder end of the 256-bit line interface that the L2 cache drives (pmem_address/rdata/wdata/read/write/resp).
- Converts each line read or write into a 4-beat, 64-bit burst on the physical memory bus.
- Sits between the L2 cache and main memory; serves one line transaction at a time.

---
 rtl/cacheline_burst_adaptor.sv | 119 +++++++++++
 1 files changed

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor
// Responder for the L2 line interface. Each line read or write becomes a
// fixed-length burst of BURST_LEN beats on the physical memory bus, lowest
// beat first, with the aligned line address held for the whole burst.
// One line transaction is in flight at a time.
// LINE_WIDTH must equal BEAT_WIDTH * BURST_LEN.
module cacheline_burst_adaptor #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           line_address,
    output logic [LINE_WIDTH-1:0] line_rdata,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    input  logic                  line_read,
    input  logic                  line_write,
    output logic                  line_resp,
    output logic [31:0]           burst_address,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    output logic                  burst_read,
    output logic                  burst_write,
    input  logic                  burst_resp
);

    localparam int            CW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    // Separate buffers: a write never disturbs the read line visible on line_rdata.
    logic [LINE_WIDTH-1:0] wbuf_q, wbuf_d;
    logic [LINE_WIDTH-1:0] rbuf_q, rbuf_d;
    logic                  beat_last;

    // Offset bits inside the line are not needed; the burst always starts at the line base.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^line_address[4:0];

    assign beat_last = (cnt_q == LAST_BEAT);

    // Next-state logic: accept in IDLE (read wins), count beats on burst_resp, pulse DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            S_IDLE: begin
                if (line_read) begin
                    addr_d  = {line_address[31:5], 5'b0};
                    state_d = S_READ;
                end else if (line_write) begin
                    addr_d  = {line_address[31:5], 5'b0};
                    wbuf_d  = line_wdata;
                    state_d = S_WRITE;
                end
            end
            S_READ: begin
                if (burst_resp) begin
                    rbuf_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
                    if (beat_last) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (burst_resp) begin
                    if (beat_last) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any burst and clears all visible data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
        end
    end

    assign burst_read    = (state_q == S_READ);
    assign burst_write   = (state_q == S_WRITE);
    assign line_resp     = (state_q == S_DONE);
    assign burst_address = addr_q;
    assign line_rdata    = rbuf_q;
    assign burst_wdata   = (state_q == S_WRITE) ?
                           wbuf_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] : '0;

endmodule
